sysid_check_master: RTL
=======================

// Module: sysid_check_master
// PURPOSE
//  Avalon-MM read master that verifies the system ID peripheral after reset or on request.
//  Reads word 0 (system ID) and word 1 (build timestamp), compares them against expected
//  parameters and reports pass/fail.
//  Sits between the reset/boot sequencer and the sysid control slave. Gates video-pipeline
//  enable so the pipeline never runs against a mismatched hardware image.
// PARAMETERS
//  EXP_ID      32'h11223344  expected system ID (word 0)
//  EXP_TS      32'h56FD1B26  expected build timestamp (word 1)
//  TIMEOUT     255           max cycles waitrequest may stay high per read; range 1..65535
//  RETRIES     3             extra full read attempts after a mismatch or timeout; range 0..15
//  AUTO_START  1             1 = start one check automatically after reset release
// PORTS
//  clock          in   1   system clock
//  reset_n        in   1   synchronous active-low reset
//  start          in   1   pulse: begin check; ignored unless state==IDLE or DONE
//  busy           out  1   high from accepted start until DONE
//  done           out  1   one-cycle pulse on entering DONE
//  pass           out  1   sticky result of last check; 1 = ID and TS matched
//  id_ok          out  1   sticky: last ID read matched EXP_ID
//  ts_ok          out  1   sticky: last TS read matched EXP_TS
//  timed_out      out  1   sticky: final attempt ended on a timeout
//  attempts       out  4   attempts used in last check (1..RETRIES+1)
//  cap_id         out  32  last captured ID word
//  cap_ts         out  32  last captured TS word
//  avm_address    out  1   word address: 0 = ID, 1 = TS
//  avm_read       out  1   read strobe
//  avm_readdata   in   32  read data; valid in the cycle avm_read=1 and avm_waitrequest=0
//  avm_waitrequest in  1   slave stall
// BEHAVIOUR
//  Reset (reset_n=0 at a clock edge), all outputs:
//   busy=0, done=0, pass=0, id_ok=0, ts_ok=0, timed_out=0, attempts=0.
//   cap_id=0, cap_ts=0, avm_read=0, avm_address=0. State returns to IDLE.
//   Reset asserted mid-read drops avm_read on the next edge; the bus read is abandoned.
//  FSM:
//   IDLE: on start, or on the first cycle after reset release when AUTO_START=1:
//    clear results, attempts=1, go to RD_ID.
//   RD_ID: avm_read=1, avm_address=0; hold both stable while avm_waitrequest=1.
//    On accept: cap_id<=readdata, go to RD_TS.
//   RD_TS: same handshake with avm_address=1. On accept: cap_ts<=readdata, go to CHECK.
//   CHECK (1 cycle): id_ok=(cap_id==EXP_ID), ts_ok=(cap_ts==EXP_TS).
//    Both ok: pass=1, go to DONE.
//    Otherwise, if attempts<=RETRIES: attempts++, go to RD_ID.
//    Otherwise: pass=0, go to DONE.
//   DONE: done=1 for this cycle only. Results hold. start re-enters as from IDLE.
//  Timing and handshake:
//   Latency with zero wait states: start at cycle N; reads accepted N+1 and N+2;
//    CHECK at N+3; done at N+4.
//   Wait counter resets on each new read. If it reaches TIMEOUT while waitrequest=1:
//    drop avm_read for one cycle, set timed_out, then treat as mismatch (retry or DONE).
//    timed_out clears if a later attempt completes both reads.
//   avm_read never asserts outside RD_ID/RD_TS. At most one outstanding read.
//   start while busy is ignored (no queueing).
//   start in the same cycle as DONE is accepted; the next cycle enters RD_ID.
//   Comparison is full 32-bit equality; no masking.
// STRUCTURE
//  Shared package sysid_pkg: state enum (IDLE, RD_ID, RD_TS, CHECK, DONE) and
//   SYSID_WORD_ID=1'b0, SYSID_WORD_TS=1'b1.
//  One sub-module: avm_read_timeout, the wait/timeout counter. Inputs: read active and
//   waitrequest. Output: one-cycle expire pulse.
//  FSM, capture registers and compare stay in this module.
// TESTING
//  1 Slave returns 0x11223344/0x56FD1B26, no waits -> done at start+4, pass=1, attempts=1.
//  2 TS word returns 0x56FD1B27 always, RETRIES=3 -> 4 attempts, pass=0, id_ok=1, ts_ok=0.
//  3 Waitrequest held 300 cycles on first ID read, TIMEOUT=255 -> read dropped at 255,
//    retry passes, timed_out=0, attempts=2.
//  4 Reset_n low for 1 cycle during RD_TS wait -> next cycle avm_read=0, all outputs at
//    reset values, auto-check reruns.
//  5 start pulsed while busy and again coincident with done -> first ignored, second
//    starts a new check (attempts=1).
//  6 Random 0-5 waitrequest stalls -> avm_address/avm_read stable during stalls (assertion).

Source files
------------

// File: rtl/sysid_pkg.sv
// Shared types and constants for the system ID check master and its helpers.
// Holds the FSM state encoding and the sysid slave word map.
package sysid_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    RD_TS,
    CHECK,
    DONE
  } state_t;

  localparam logic SYSID_WORD_ID = 1'b0;
  localparam logic SYSID_WORD_TS = 1'b1;

  // Wait counter width; large enough for the full TIMEOUT range.
  localparam int unsigned SYSID_WAIT_W = 16;

endpackage

// File: rtl/avm_read_timeout.sv
// Wait-state counter for one Avalon-MM read: counts consecutive stalled cycles
// and pulses expire on the TIMEOUT-th stalled cycle of the same read.
module avm_read_timeout
  import sysid_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic read_active,
  input  logic waitrequest,
  output logic expire
);

  localparam logic [SYSID_WAIT_W-1:0] LAST = SYSID_WAIT_W'(TIMEOUT - 1);

  logic                    waiting;
  logic [SYSID_WAIT_W-1:0] wait_cnt;

  assign waiting = read_active && waitrequest;
  assign expire  = waiting && (wait_cnt == LAST);

  // Any accepted or dropped read returns the count to zero, so each new read
  // starts from a clean budget.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (waiting && !expire) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

endmodule

// File: rtl/sysid_check_master.sv
// Avalon-MM read master that fetches the sysid ID and timestamp words, compares them
// against the expected image, retries on mismatch/timeout and reports a sticky result.
module sysid_check_master
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXP_ID     = 32'h11223344,
  parameter logic [31:0] EXP_TS     = 32'h56FD1B26,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned RETRIES    = 3,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timed_out,
  output logic [3:0]  attempts,
  output logic [31:0] cap_id,
  output logic [31:0] cap_ts,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest
);

  localparam logic [4:0] RETRY_LIMIT = 5'(RETRIES);

  state_t state;
  logic   auto_pend;
  logic   tmo_hit;
  logic   expire;
  logic   start_ok;
  logic   match;
  logic   retry_ok;

  avm_read_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clock       (clock),
    .reset_n     (reset_n),
    .read_active (avm_read),
    .waitrequest (avm_waitrequest),
    .expire      (expire)
  );

  assign start_ok = ((state == IDLE) && (start || auto_pend)) || ((state == DONE) && start);
  assign match    = !tmo_hit && (cap_id == EXP_ID) && (cap_ts == EXP_TS);
  // The 4-bit attempts field caps the total at 15 even when RETRIES is 15.
  assign retry_ok = ({1'b0, attempts} <= RETRY_LIMIT) && (attempts != 4'hF);

  // NOTE: every register here uses non-blocking assignment so all of them update
  // from the same pre-edge values; reset is synchronous and covers every output.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      auto_pend   <= AUTO_START;
      tmo_hit     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timed_out   <= 1'b0;
      attempts    <= '0;
      cap_id      <= '0;
      cap_ts      <= '0;
      avm_read    <= 1'b0;
      avm_address <= SYSID_WORD_ID;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            state       <= RD_ID;
            auto_pend   <= 1'b0;
            tmo_hit     <= 1'b0;
            busy        <= 1'b1;
            pass        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timed_out   <= 1'b0;
            attempts    <= 4'd1;
            cap_id      <= '0;
            cap_ts      <= '0;
            avm_read    <= 1'b1;
            avm_address <= SYSID_WORD_ID;
          end else if (state == DONE) begin
            state <= IDLE;
          end
        end

        RD_ID: begin
          if (expire) begin
            avm_read  <= 1'b0;
            timed_out <= 1'b1;
            tmo_hit   <= 1'b1;
            state     <= CHECK;
          end else if (!avm_waitrequest) begin
            cap_id      <= avm_readdata;
            avm_address <= SYSID_WORD_TS;
            state       <= RD_TS;
          end
        end

        RD_TS: begin
          if (expire) begin
            avm_read  <= 1'b0;
            timed_out <= 1'b1;
            tmo_hit   <= 1'b1;
            state     <= CHECK;
          end else if (!avm_waitrequest) begin
            cap_ts   <= avm_readdata;
            avm_read <= 1'b0;
            state    <= CHECK;
          end
        end

        CHECK: begin
          id_ok <= (cap_id == EXP_ID);
          ts_ok <= (cap_ts == EXP_TS);
          if (!tmo_hit) begin
            timed_out <= 1'b0;
          end
          if (match) begin
            pass  <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (retry_ok) begin
            attempts    <= attempts + 4'd1;
            tmo_hit     <= 1'b0;
            avm_read    <= 1'b1;
            avm_address <= SYSID_WORD_ID;
            state       <= RD_ID;
          end else begin
            pass  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
